// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift engine: op encodings, FSM states, default sizes.
// No logic; constants and types only.
// Imported by shift_step and shift_arbiter.
package shift_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SHAMT_W = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift of the accumulator by op (the engine's only datapath element).
// Latency: combinational. Backpressure: none, pure function of inputs.
// Macro SHIFT_ARB_ROR_EN: when defined, op 11 rotates right; otherwise op 11 passes acc through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] acc_in,
    output logic [WIDTH-1:0] acc_out
);

    // Select the single-bit step for the latched op.
    always_comb begin
        acc_out = acc_in;
        case (op)
            OP_SLL:  acc_out = {acc_in[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_out = {1'b0, acc_in[WIDTH-1:1]};
            OP_SRA:  acc_out = {acc_in[WIDTH-1], acc_in[WIDTH-1:1]};
`ifdef SHIFT_ARB_ROR_EN
            OP_ROR:  acc_out = {acc_in[0], acc_in[WIDTH-1:1]};
`endif
            default: acc_out = acc_in;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbitrated iterative shifter: two requesters share one 1-bit/cycle shift engine.
// Latency: response valid shamt+1 cycles after the accept cycle (1 cycle for shamt 0 or illegal op).
// Backpressure: result held in DONE until rsp_ready; no request is accepted until the cycle after that.
// Macro SHIFT_ARB_ROR_EN: enables op 11 (rotate right); without it op 11 returns the operand with rsp_err.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic               id_q, id_d;
    logic               err_q, err_d;
    logic               last_q, last_d;

    logic               grant0, grant1;
    op_e                sel_op;
    logic [WIDTH-1:0]   sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic               sel_illegal;
    logic [WIDTH-1:0]   step_out;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    // Held off while reset is asserted so no handshake can slip through during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Payload of the granted requester and its legality.
    always_comb begin
        sel_op    = op_e'(grant1 ? req1_op : req0_op);
        sel_data  = grant1 ? req1_data  : req0_data;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
`ifdef SHIFT_ARB_ROR_EN
        sel_illegal = 1'b0;
`else
        sel_illegal = (sel_op == OP_ROR);
`endif
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc_in  (acc_q),
        .acc_out (step_out)
    );

    // FSM next-state and datapath update: accept in IDLE, step in SHIFT, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        id_d    = id_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    acc_d  = sel_data;
                    cnt_d  = sel_shamt;
                    op_d   = sel_op;
                    id_d   = grant1;
                    last_d = grant1;
                    err_d  = sel_illegal;
                    // Illegal ops skip shifting so the operand comes back untouched.
                    if (sel_illegal || sel_shamt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_out;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            id_q    <= id_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = acc_q;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_data = '0, req1_data = '0;
    logic [SW-1:0] req0_shamt = '0, req1_shamt = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
    logic [W-1:0]  rsp_data;

    shift_arbiter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  data;
        logic [SW-1:0] sh;
    } req_t;

    req_t q0[$], q1[$];
    int   grants[$];
    int   total = 0, bad = 0;

    // Transaction-level reference: busy flag, cycles until response, expected response, RR pointer.
    logic         m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
    int           m_wait = 0;
    logic [W-1:0] m_data = '0;
    int           hold = 0;
    int           rdy_pct = 100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected result, error flag and accept-to-valid latency from the op's arithmetic meaning.
    function automatic void model(input req_t r, output logic [W-1:0] d, output logic e, output int lat);
        logic [2*W-1:0] dd;
        int s;
        s   = int'(r.sh);
        e   = 1'b0;
        lat = s + 1;
        case (r.op)
            2'b00: d = r.data << s;
            2'b01: d = r.data >> s;
            2'b10: d = $unsigned($signed(r.data) >>> s);
            default: begin
`ifdef SHIFT_ARB_ROR_EN
                dd = {r.data, r.data};
                dd = dd >> s;
                d  = dd[W-1:0];
`else
                dd  = '0;
                d   = r.data;
                e   = 1'b1;
                lat = 1;
`endif
            end
        endcase
    endfunction

    task automatic push(input int who, input logic [1:0] op, input logic [W-1:0] d, input logic [SW-1:0] s);
        req_t r;
        r.op = op; r.data = d; r.sh = s;
        if (who == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    // One cycle: drive at negedge, settle, compare against the model, advance the model.
    task automatic step();
        logic exp_v, g0, g1, e;
        logic [W-1:0] d;
        int lat;
        req_t r;
        @(negedge clk);
        exp_v = m_busy && (m_wait == 0);
        req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin req0_op = q0[0].op; req0_data = q0[0].data; req0_shamt = q0[0].sh; end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin req1_op = q1[0].op; req1_data = q1[0].data; req1_shamt = q1[0].sh; end
        if (exp_v && hold > 0) begin
            rsp_ready = 1'b0;
            hold--;
        end else begin
            rsp_ready = ($urandom_range(99) < rdy_pct);
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        g0 = !m_busy && req0_valid && (!req1_valid || m_last);
        g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (g0 || g1) begin
            if (g0) r = q0.pop_front(); else r = q1.pop_front();
            model(r, d, e, lat);
            m_busy = 1'b1; m_wait = lat; m_data = d; m_err = e; m_id = g1; m_last = g1;
            grants.push_back(g1 ? 1 : 0);
        end
        if (exp_v && rsp_ready) m_busy = 1'b0;
        if (m_wait > 0) m_wait--;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < 400) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n >= 400), 32'd0);
    endtask

    initial begin
        // Reset state with both requesters asserting valid: nothing may be granted.
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #3; rst_n = 1'b1;

        // Long SLL from requester 0.
        push(0, OP_SLL, 16'h0001, 4'd15);
        drain();
        // Arithmetic vs logical right shift from requester 1.
        push(1, OP_SRA, 16'h8000, 4'd4);
        push(1, OP_SRL, 16'h8000, 4'd4);
        drain();

        // Both requesters contending with zero shifts: strict alternation 0,1,0,1...
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, OP_SLL, 16'(16'h0100 + i), 4'd0);
            push(1, OP_SRL, 16'(16'h0200 + i), 4'd0);
        end
        drain();
        chk("alt_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size(); i++) chk("alt_grant", 32'(grants[i]), 32'(i % 2));

        // Consumer stalls 5 cycles in DONE, then the queued request follows.
        hold = 5;
        push(0, OP_SRL, 16'hABCD, 4'd2);
        push(1, OP_SLL, 16'h00F0, 4'd3);
        drain();

        // Op 11 behaviour depends on the build.
        push(0, 2'b11, 16'h0001, 4'd1);
        push(1, 2'b11, 16'h1234, 4'd9);
        drain();

        // Randomised traffic with a sluggish consumer.
        rdy_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && $urandom_range(1) == 1)
                push(0, 2'($urandom_range(3)), 16'($urandom), 4'($urandom_range(15)));
            if (q1.size() == 0 && $urandom_range(1) == 1)
                push(1, 2'($urandom_range(3)), 16'($urandom), 4'($urandom_range(15)));
            step();
        end
        drain();
        rdy_pct = 100;

        // Reset in the middle of a shift: outputs clear immediately, no response afterwards.
        push(0, OP_SLL, 16'h0001, 4'd8);
        for (int n = 0; n < 10 && !m_busy; n++) step();
        chk("mid_accepted", 32'(m_busy), 32'd1);
        repeat (3) step();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #2; rst_n = 1'b0; #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_req0_ready", 32'(req0_ready), 32'd0);
        chk("mid_req1_ready", 32'(req1_ready), 32'd0);
        q0.delete(); q1.delete();
        m_busy = 1'b0; m_wait = 0; m_last = 1'b1;
        @(posedge clk); #3; rst_n = 1'b1;
        repeat (20) step();

        // After reset requester 0 wins the first tie again.
        grants.delete();
        push(0, OP_SRA, 16'hF00F, 4'd0);
        push(1, OP_SRA, 16'h0FF0, 4'd0);
        drain();
        chk("post_rst_first_grant", 32'(grants.size() > 0 ? grants[0] : 9), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
